// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 24-bit pipeline around execute:
// stage enables, flush/bubble control, operand forwarding and perf counters.
module pipeline_hazard_ctrl #(
    parameter int REG_BITS    = 4,
    parameter int LOAD_LAT    = 1,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_BITS-1:0]  idRs1,
    input  logic [REG_BITS-1:0]  idRs2,
    input  logic                 idRs1Used,
    input  logic                 idRs2Used,
    input  logic                 exRegWe,
    input  logic                 exWriteRegFromAlu,
    input  logic [REG_BITS-1:0]  exRegToWrite,
    input  logic                 exPcWe,
    input  logic                 memRegWe,
    input  logic [REG_BITS-1:0]  memRegToWrite,
    input  logic                 memBusy,
    output logic                 fetchEn,
    output logic                 decodeEn,
    output logic                 executeEn,
    output logic                 memStageEn,
    output logic                 decodeFlush,
    output logic                 exBubble,
    output logic [1:0]           forwardA,
    output logic [1:0]           forwardB,
    output logic                 memError,
    output logic [CNT_WIDTH-1:0] stallCycles,
    output logic [CNT_WIDTH-1:0] flushCount
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_ZERO = WAIT_W'(0);
    localparam logic [3:0] STALL_INIT = 4'(LOAD_LAT - 1);

    // {fetchEn, decodeEn, executeEn, memStageEn, decodeFlush, exBubble}
    localparam logic [5:0] CTL_RUN    = 6'b111100;
    localparam logic [5:0] CTL_STALL  = 6'b001101;
    localparam logic [5:0] CTL_BRANCH = 6'b111111;
    localparam logic [5:0] CTL_FREEZE = 6'b000000;

    typedef enum logic [1:0] {RUN = 2'd0, LOAD_STALL = 2'd1, MEM_WAIT = 2'd2} state_t;

    state_t              state_r, nextState_s;
    logic [3:0]          stallLeft_r, nextStall_s;
    logic [WAIT_W-1:0]   waitCnt_r, nextWait_s;
    logic [5:0]          ctl_s;
    logic                countFlush_s;
    logic                loadUse_s;
    logic                memError_r;

    function automatic logic [1:0] fwdSel(
        input logic [REG_BITS-1:0] rs,
        input logic                exWe,
        input logic                exAlu,
        input logic [REG_BITS-1:0] exRd,
        input logic                memWe,
        input logic [REG_BITS-1:0] memRd
    );
        if (exWe && exAlu && (exRd == rs)) begin
            return 2'b01;
        end else if (memWe && (memRd == rs)) begin
            return 2'b10;
        end else begin
            return 2'b00;
        end
    endfunction

    function automatic logic [CNT_WIDTH-1:0] satInc(input logic [CNT_WIDTH-1:0] v);
        return (v == {CNT_WIDTH{1'b1}}) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign loadUse_s = exRegWe && !exWriteRegFromAlu &&
                       ((idRs1Used && (idRs1 == exRegToWrite)) ||
                        (idRs2Used && (idRs2 == exRegToWrite)));

    assign {fetchEn, decodeEn, executeEn, memStageEn, decodeFlush, exBubble} = ctl_s;
    assign memError = memError_r;

    // Stage control and next-state decision; a released memory wait applies the RUN rules at once.
    always_comb begin
        ctl_s        = CTL_FREEZE;
        nextState_s  = state_r;
        nextStall_s  = stallLeft_r;
        nextWait_s   = waitCnt_r;
        countFlush_s = 1'b0;
        if (!reset) begin
            nextState_s = RUN;
        end else begin
            case (state_r)
                RUN, MEM_WAIT: begin
                    if (memBusy) begin
                        ctl_s       = CTL_FREEZE;
                        nextState_s = MEM_WAIT;
                        if (state_r == RUN) begin
                            nextWait_s = WAIT_ONE;
                        end else if (waitCnt_r != WAIT_MAX) begin
                            nextWait_s = waitCnt_r + WAIT_ONE;
                        end else begin
                            nextWait_s = waitCnt_r;
                        end
                    end else if (stallLeft_r != 4'd0) begin
                        // A load stall interrupted by memory resumes where it left off.
                        ctl_s       = CTL_STALL;
                        nextWait_s  = WAIT_ZERO;
                        nextStall_s = stallLeft_r - 4'd1;
                        nextState_s = (stallLeft_r == 4'd1) ? RUN : LOAD_STALL;
                    end else if (exPcWe) begin
                        ctl_s        = CTL_BRANCH;
                        countFlush_s = 1'b1;
                        nextWait_s   = WAIT_ZERO;
                        nextState_s  = RUN;
                    end else if (loadUse_s) begin
                        ctl_s      = CTL_STALL;
                        nextWait_s = WAIT_ZERO;
                        if (STALL_INIT != 4'd0) begin
                            nextStall_s = STALL_INIT;
                            nextState_s = LOAD_STALL;
                        end else begin
                            nextState_s = RUN;
                        end
                    end else begin
                        ctl_s       = CTL_RUN;
                        nextWait_s  = WAIT_ZERO;
                        nextState_s = RUN;
                    end
                end
                LOAD_STALL: begin
                    if (memBusy) begin
                        ctl_s       = CTL_FREEZE;
                        nextWait_s  = WAIT_ONE;
                        nextState_s = MEM_WAIT;
                    end else begin
                        ctl_s       = CTL_STALL;
                        nextStall_s = stallLeft_r - 4'd1;
                        nextState_s = (stallLeft_r == 4'd1) ? RUN : LOAD_STALL;
                    end
                end
                default: begin
                    ctl_s       = CTL_FREEZE;
                    nextStall_s = 4'd0;
                    nextWait_s  = WAIT_ZERO;
                    nextState_s = RUN;
                end
            endcase
        end
    end

    // Operand forwarding selects; execute results win over memory-stage results.
    always_comb begin
        forwardA = 2'b00;
        forwardB = 2'b00;
        if (reset) begin
            forwardA = fwdSel(idRs1, exRegWe, exWriteRegFromAlu, exRegToWrite, memRegWe, memRegToWrite);
            forwardB = fwdSel(idRs2, exRegWe, exWriteRegFromAlu, exRegToWrite, memRegWe, memRegToWrite);
        end else begin
            forwardA = 2'b00;
            forwardB = 2'b00;
        end
    end

    // State, stall/wait counters, sticky timeout flag and saturating perf counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= RUN;
            stallLeft_r <= 4'd0;
            waitCnt_r   <= WAIT_ZERO;
            memError_r  <= 1'b0;
            stallCycles <= {CNT_WIDTH{1'b0}};
            flushCount  <= {CNT_WIDTH{1'b0}};
        end else begin
            state_r     <= nextState_s;
            stallLeft_r <= nextStall_s;
            waitCnt_r   <= nextWait_s;
            if (memBusy && (nextWait_s == WAIT_MAX)) begin
                memError_r <= 1'b1;
            end
            if (!fetchEn) begin
                stallCycles <= satInc(stallCycles);
            end
            if (countFlush_s) begin
                flushCount <= satInc(flushCount);
            end
        end
    end
endmodule
